// File: rtl/instr_fetch.sv
// Instruction fetch sequencer: latches PC into MAR, reads memory with an optional
// timeout, and holds the fetched word in IR until decode accepts it.
module instr_fetch #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] pc,
  input  logic        start,
  input  logic        flush,
  output logic [15:0] mem_addr,
  output logic        mem_rd,
  input  logic        mem_ready,
  input  logic [15:0] mem_rdata,
  output logic        ld_pc,
  output logic [15:0] ir,
  output logic        ir_valid,
  input  logic        ir_ready,
  output logic        busy,
  output logic        fault
);

  localparam int unsigned CW = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_MAX = '1;
  localparam logic [CW-1:0] CNT_TMO = CW'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_WAIT,
    S_HOLD,
    S_FAULT
  } state_t;

  state_t          state_q, state_d;
  logic [15:0]     mar_q, mar_d;
  logic [15:0]     ir_q, ir_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [CW-1:0]   cnt_inc;

  // State and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      mar_q   <= '0;
      ir_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      mar_q   <= mar_d;
      ir_q    <= ir_d;
      cnt_q   <= cnt_d;
    end
  end

  // Saturating increment so the wait counter never wraps when the timeout is disabled
  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);

  // Next-state and output decode
  always_comb begin
    state_d  = state_q;
    mar_d    = mar_q;
    ir_d     = ir_q;
    cnt_d    = cnt_q;
    mem_rd   = 1'b0;
    ld_pc    = 1'b0;
    ir_valid = 1'b0;
    busy     = 1'b1;
    fault    = 1'b0;

    case (state_q)
      S_IDLE: begin
        busy = 1'b0;
        if (start) begin
          state_d = S_ADDR;
          mar_d   = pc;
        end
      end
      S_ADDR: begin
        ld_pc   = !flush;
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        mem_rd = 1'b1;
        if (mem_ready) begin
          ir_d    = mem_rdata;
          cnt_d   = '0;
          state_d = S_HOLD;
        end else begin
          cnt_d = cnt_inc;
          if ((TIMEOUT != 0) && (cnt_inc == CNT_TMO)) state_d = S_FAULT;
        end
      end
      S_HOLD: begin
        ir_valid = 1'b1;
        if (ir_ready) begin
          if (start) begin
            state_d = S_ADDR;
            mar_d   = pc;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_FAULT: begin
        fault = 1'b1;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Flush overrides every other request; IR and MAR keep their contents
    if (flush) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      ir_d    = ir_q;
      mar_d   = mar_q;
    end
  end

  assign mem_addr = mar_q;
  assign ir       = ir_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: default-timeout instance for fetch paths and a
// TIMEOUT=4 instance for the fault path, both on shared stimulus.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] pc;
  logic        start, flush, mem_ready, ir_ready;
  logic [15:0] mem_rdata;

  logic [15:0] mem_addr, ir;
  logic        mem_rd, ld_pc, ir_valid, busy, fault;
  logic [15:0] t_mem_addr, t_ir;
  logic        t_mem_rd, t_ld_pc, t_ir_valid, t_busy, t_fault;

  int n_checks = 0;
  int n_fail   = 0;
  logic [15:0] exp_q[$];

  always #5 clk = ~clk;

  instr_fetch dut (
    .clk(clk), .rst(rst), .pc(pc), .start(start), .flush(flush),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .ld_pc(ld_pc), .ir(ir), .ir_valid(ir_valid), .ir_ready(ir_ready),
    .busy(busy), .fault(fault)
  );

  instr_fetch #(.TIMEOUT(4)) dut4 (
    .clk(clk), .rst(rst), .pc(pc), .start(start), .flush(flush),
    .mem_addr(t_mem_addr), .mem_rd(t_mem_rd), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .ld_pc(t_ld_pc), .ir(t_ir), .ir_valid(t_ir_valid), .ir_ready(ir_ready),
    .busy(t_busy), .fault(t_fault)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Compare IR against the oldest expected capture
  task automatic pop_ir(input string tag);
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s got=%h exp=<scoreboard empty>", tag, ir);
    end else begin
      chk(tag, 32'(ir), 32'(exp_q.pop_front()));
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_addr"}, 32'(mem_addr), 32'h0);
    chk({tag, "_ctl"}, {27'h0, mem_rd, ld_pc, ir_valid, busy, fault}, 32'h0);
    chk({tag, "_ir"}, 32'(ir), 32'h0);
  endtask

  initial begin
    rst = 1'b0; pc = 16'h0; start = 1'b0; flush = 1'b0;
    mem_ready = 1'b0; ir_ready = 1'b0; mem_rdata = 16'h0;

    // Reset state
    tick(); tick();
    chk_all_zero("reset");
    rst = 1'b1;
    tick();
    chk("idle_after_rst_busy", 32'(busy), 32'h0);

    // Zero-wait fetch and latency
    pc = 16'h3000; start = 1'b1;
    tick();
    start = 1'b0; mem_ready = 1'b1; mem_rdata = 16'h1234;
    exp_q.push_back(16'h1234);
    chk("addr_ld_pc", 32'(ld_pc), 32'h1);
    chk("addr_mem_addr", 32'(mem_addr), 32'h3000);
    chk("addr_mem_rd", 32'(mem_rd), 32'h0);
    tick();
    chk("wait_mem_rd", 32'(mem_rd), 32'h1);
    chk("wait_ld_pc", 32'(ld_pc), 32'h0);
    tick();
    mem_ready = 1'b0;
    chk("hold_ir_valid", 32'(ir_valid), 32'h1);
    pop_ir("ir_zero_wait");
    ir_ready = 1'b1;
    tick();
    ir_ready = 1'b0;
    chk("after_accept_ir", 32'(ir), 32'h1234);
    chk("after_accept_valid", {30'h0, ir_valid, busy}, 32'h0);

    // Five wait states then ready
    pc = 16'h4000; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("wait%0d_rd", i), 32'(mem_rd), 32'h1);
      chk($sformatf("wait%0d_addr", i), 32'(mem_addr), 32'h4000);
      tick();
    end
    mem_ready = 1'b1; mem_rdata = 16'hBEEF;
    exp_q.push_back(16'hBEEF);
    chk("wait6_rd", 32'(mem_rd), 32'h1);
    tick();
    mem_ready = 1'b0;
    pop_ir("ir_slow");
    chk("slow_valid_fault", {30'h0, ir_valid, fault}, 32'h2);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_hold_ir", 32'(ir), 32'hBEEF);
    chk("flush_hold_valid", {30'h0, ir_valid, busy}, 32'h0);
    chk("t_fault_flushed", 32'(t_fault), 32'h0);

    // Timeout on the TIMEOUT=4 instance
    pc = 16'h5000; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t_wait%0d", i), {30'h0, t_mem_rd, t_fault}, 32'h2);
      tick();
    end
    chk("t_fault_state", {29'h0, t_fault, t_mem_rd, t_busy}, 32'h5);
    pc = 16'h5555; start = 1'b1;
    tick();
    start = 1'b0;
    chk("t_fault_ignores_start", {29'h0, t_fault, t_ld_pc, t_busy}, 32'h5);
    chk("t_fault_mar", 32'(t_mem_addr), 32'h5000);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("t_flush_fault", {30'h0, t_fault, t_busy}, 32'h0);

    // HOLD stalls, then back-to-back fetch
    pc = 16'h3000; start = 1'b1;
    tick();
    start = 1'b0; mem_ready = 1'b1; mem_rdata = 16'hA5A5;
    exp_q.push_back(16'hA5A5);
    tick();
    tick();
    mem_rdata = 16'hFFFF;
    pop_ir("ir_hold_first");
    for (int i = 0; i < 10; i++) begin
      tick();
      chk($sformatf("hold%0d_ir", i), 32'(ir), 32'hA5A5);
      chk($sformatf("hold%0d_valid", i), 32'(ir_valid), 32'h1);
    end
    ir_ready = 1'b1; start = 1'b1; pc = 16'h3001;
    tick();
    ir_ready = 1'b0; start = 1'b0; mem_ready = 1'b0;
    chk("b2b_addr", 32'(mem_addr), 32'h3001);
    chk("b2b_ld_pc", {30'h0, ld_pc, ir_valid}, 32'h2);
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;

    // Flush during ADDR suppresses ld_pc
    pc = 16'h6000; start = 1'b1;
    tick();
    start = 1'b0; flush = 1'b1;
    #1;
    chk("flush_addr_ld_pc", 32'(ld_pc), 32'h0);
    tick();
    flush = 1'b0;
    chk("flush_addr_idle", 32'(busy), 32'h0);

    // Asynchronous reset mid-WAIT
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("pre_rst_wait", 32'(mem_rd), 32'h1);
    #2;
    rst = 1'b0;
    #1;
    chk_all_zero("async_rst");
    tick();
    rst = 1'b1;
    tick();
    chk("post_rst", {29'h0, mem_rd, ld_pc, busy}, 32'h0);

    chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter TIMEOUT, default 16: maximum WAIT cycles before a fault; 0 disables the timeout.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low (0 = reset asserted).
REQ-004 pc  input  16  current program counter from the PC register.
REQ-005 start  input  1  request from control to begin an instruction fetch.
REQ-006 flush  input  1  abort the current fetch and clear any fault.
REQ-007 mem_addr  output  16  memory address, driven from the internal MAR register.
REQ-008 mem_rd  output  1  memory read strobe.
REQ-009 mem_ready  input  1  memory has valid mem_rdata in this cycle.
REQ-010 mem_rdata  input  16  memory read data.
REQ-011 ld_pc  output  1  one-cycle load strobe to the PC register (increment select is held externally).
REQ-012 ir  output  16  registered instruction word.
REQ-013 ir_valid  output  1  ir holds an unconsumed instruction.
REQ-014 ir_ready  input  1  decode accepts ir this cycle.
REQ-015 busy  output  1  block is not in IDLE.
REQ-016 fault  output  1  memory timeout occurred (sticky).

Function
REQ-017 The FSM SHALL have the states IDLE, ADDR, WAIT, HOLD and FAULT.
REQ-018 IDLE: busy=0; if start=1 at an edge, the block SHALL load MAR<=pc and go to ADDR; otherwise it stays in IDLE.
REQ-019 ADDR: lasts exactly one cycle; ld_pc = (state==ADDR) && !flush; the next state SHALL be WAIT.
REQ-020 WAIT: mem_rd=1 and mem_addr=MAR, both held stable; the wait counter increments each cycle that mem_ready=0.
REQ-021 WAIT with mem_ready=1 at an edge: the block SHALL load ir<=mem_rdata, clear the counter and go to HOLD.
REQ-022 WAIT with TIMEOUT!=0 and the counter reaching TIMEOUT with mem_ready still 0: the block SHALL go to FAULT.
REQ-023 The counter SHALL be $clog2(TIMEOUT+1) bits wide (minimum 1) and SHALL never wrap.
REQ-024 mem_ready SHALL be ignored in every state except WAIT; mem_rd SHALL be 0 outside WAIT.
REQ-025 HOLD: ir_valid=1 and ir is held stable; on ir_ready=1 the block SHALL go to ADDR if start=1 in the same cycle (MAR<=pc), otherwise to IDLE.
REQ-026 FAULT: fault=1, busy=1, mem_rd=0; start is ignored; the state is left only by flush or reset.
REQ-027 Latency with a zero-wait memory: start sampled at edge E0 -> ADDR in cycle 1 -> WAIT in cycle 2 -> ir_valid=1 after edge E2.
REQ-028 flush=1 at an edge SHALL force IDLE from any state, clear fault and the counter, drop ir_valid, and leave ir unchanged.
REQ-029 flush SHALL have priority over start, mem_ready and ir_ready in the same cycle.
REQ-030 busy SHALL be 1 in ADDR, WAIT, HOLD and FAULT.
REQ-031 ir SHALL change only on a WAIT capture (REQ-021); it retains its value after the ir_ready handshake.

Reset
REQ-032 rst=0 SHALL immediately force IDLE, MAR=0, ir=0, counter=0 and fault=0, with every output at 0 and independent of clk.
REQ-033 Release of rst SHALL take effect at the first clk edge with rst=1; no fetch starts unless start=1 at that edge.
REQ-034 rst asserted mid-fetch SHALL discard the fetch and issue no further ld_pc or mem_rd.

Verification
REQ-035 pc=0x3000, start pulse, mem_ready=1 on the first WAIT cycle with mem_rdata=0x1234 -> mem_addr=0x3000, ld_pc high for exactly 1 cycle, ir=0x1234 and ir_valid=1 after edge E2.
REQ-036 mem_ready held low for 5 WAIT cycles, then high -> mem_rd high for 6 cycles with mem_addr constant; ir is captured on the 6th cycle; fault=0.
REQ-037 TIMEOUT=4, mem_ready never asserted -> FAULT after 4 WAIT cycles; fault=1, mem_rd=0; start is ignored; flush -> IDLE with fault=0.
REQ-038 ir_ready low for 10 cycles in HOLD -> ir and ir_valid stable; ir_ready=1 with start=1 and pc=0x3001 -> ADDR next cycle, mem_addr=0x3001.
REQ-039 flush=1 during ADDR -> ld_pc=0 in that cycle and IDLE next; rst=0 mid-WAIT -> all outputs 0 asynchronously, before the next clk edge.
